// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : RUN / FREEZE controller state
//   STG_*        : stage indices into the stall vector
//   FL_*         : register indices into the flush vector
//   pipe_ctrl_t  : bundle of the five stall and three flush bits
//   load_use_hit : load-use hazard detection between EX and ID
package pipe_hazard_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_FREEZE = 1'b1
   } state_t;

   localparam int NUM_STALL = 5;
   localparam int NUM_FLUSH = 3;

   // Stall vector indices (PC and the four pipeline registers)
   localparam int STG_PC     = 0;
   localparam int STG_IF_ID  = 1;
   localparam int STG_ID_EX  = 2;
   localparam int STG_EX_MEM = 3;
   localparam int STG_MEM_WB = 4;

   // Flush vector indices (only these three registers take bubbles)
   localparam int FL_IF_ID  = 0;
   localparam int FL_ID_EX  = 1;
   localparam int FL_EX_MEM = 2;

   typedef struct packed {
      logic [NUM_STALL-1:0] stall;
      logic [NUM_FLUSH-1:0] flush;
   } pipe_ctrl_t;

   // A load in EX whose destination is read by the ID instruction.
   // x0 never creates a dependency.
   function automatic logic load_use_hit(
      input logic       ex_memread,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       id_use_rs1,
      input logic       id_use_rs2
   );
      return ex_memread && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: performance counters and freeze watchdog.
//   stall_any   : some stall output is high this cycle
//   flush_inc   : a redirect flush is issued this cycle
//   freeze_req  : pipeline frozen by a cache this cycle
//   freeze_exit : controller leaving FREEZE this cycle
//   cnt_clr     : clears counters and timeout_err (wins over increment)
//   stall_cnt, flush_cnt : wrapping event counters
//   timeout_err : sticky, set when the freeze timer reaches FREEZE_TMO
module hazard_perf_cnt
   import pipe_hazard_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int FREEZE_TMO = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_clr,
   input  logic             stall_any,
   input  logic             flush_inc,
   input  logic             freeze_req,
   input  logic             freeze_exit,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   localparam int TW = $clog2(FREEZE_TMO + 1);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [TW-1:0]    frz_tmr_q,   frz_tmr_d;
   logic             tmo_err_q,   tmo_err_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_any);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);

      // Timer counts consecutive frozen cycles and saturates at the limit
      frz_tmr_d = frz_tmr_q;
      if (freeze_exit) begin
         frz_tmr_d = '0;
      end else if (freeze_req && (frz_tmr_q != TW'(FREEZE_TMO))) begin
         frz_tmr_d = frz_tmr_q + TW'(1);
      end

      // Set only on the step that reaches the limit
      tmo_err_d = tmo_err_q |
                  (freeze_req && (frz_tmr_q == TW'(FREEZE_TMO - 1)));

      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         tmo_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         frz_tmr_q   <= '0;
         tmo_err_q   <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         frz_tmr_q   <= frz_tmr_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign timeout_err = tmo_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller of the 5-stage pipeline.
//   Inputs : cache stalls (im/dm), EX busy, EX redirect, load-use operands,
//            counter clear.
//   Outputs: per-register stall and flush controls (combinational, same
//            cycle), stall/flush performance counters, freeze watchdog error.
// Priority: cache freeze > EX busy > redirect > load-use.
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int FREEZE_TMO = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             im_stall,
   input  logic             dm_stall,
   input  logic             ex_busy,
   input  logic             branch_taken,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             cnt_clr,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             mem_wb_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   state_t     state_q, state_d;
   logic       pend_redirect_q, pend_redirect_d;
   pipe_ctrl_t ctrl;
   logic       freeze_req;
   logic       redirect;
   logic       redirect_fire;

   assign freeze_req = im_stall | dm_stall;
   assign redirect   = branch_taken | pend_redirect_q;

   always_comb begin
      ctrl          = '0;
      redirect_fire = 1'b0;
      if (freeze_req) begin
         ctrl.stall = '1;
      end else if (ex_busy) begin
         ctrl.stall[STG_PC]     = 1'b1;
         ctrl.stall[STG_IF_ID]  = 1'b1;
         ctrl.stall[STG_ID_EX]  = 1'b1;
         ctrl.flush[FL_EX_MEM]  = 1'b1;
      end else if (redirect) begin
         // ID instruction is squashed, so any load-use on it is moot
         ctrl.flush[FL_IF_ID]   = 1'b1;
         ctrl.flush[FL_ID_EX]   = 1'b1;
         redirect_fire          = 1'b1;
      end else if (load_use_hit(ex_memread, ex_rd, id_rs1, id_rs2,
                                id_use_rs1, id_use_rs2)) begin
         ctrl.stall[STG_PC]     = 1'b1;
         ctrl.stall[STG_IF_ID]  = 1'b1;
         ctrl.flush[FL_ID_EX]   = 1'b1;
      end
      if (rst) begin
         ctrl          = '0;
         redirect_fire = 1'b0;
      end
   end

   always_comb begin
      state_d = freeze_req ? ST_FREEZE : ST_RUN;
      // A redirect seen while held is remembered until the first advancing
      // cycle, where it is consumed by exactly one flush.
      pend_redirect_d = (freeze_req || ex_busy) ? (pend_redirect_q | branch_taken)
                                                : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RUN;
         pend_redirect_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_redirect_q <= pend_redirect_d;
      end
   end

   assign pc_stall     = ctrl.stall[STG_PC];
   assign if_id_stall  = ctrl.stall[STG_IF_ID];
   assign id_ex_stall  = ctrl.stall[STG_ID_EX];
   assign ex_mem_stall = ctrl.stall[STG_EX_MEM];
   assign mem_wb_stall = ctrl.stall[STG_MEM_WB];
   assign if_id_flush  = ctrl.flush[FL_IF_ID];
   assign id_ex_flush  = ctrl.flush[FL_ID_EX];
   assign ex_mem_flush = ctrl.flush[FL_EX_MEM];

   hazard_perf_cnt #(
      .CNT_W      (CNT_W),
      .FREEZE_TMO (FREEZE_TMO)
   ) u_perf (
      .clk         (clk),
      .rst         (rst),
      .cnt_clr     (cnt_clr),
      .stall_any   (|ctrl.stall),
      .flush_inc   (redirect_fire),
      .freeze_req  (freeze_req),
      .freeze_exit ((state_q == ST_FREEZE) && !freeze_req),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .timeout_err (timeout_err)
   );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline with I-cache and D-cache.
- Drives the per-stage stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves cache-miss freezes, load-use hazards, multi-cycle EX busy and taken-branch redirects under a fixed priority.
- Keeps performance counters and a freeze watchdog.

Parameters:
- CNT_W, 32, width of the performance counters.
- FREEZE_TMO, 1024, freeze cycles before timeout_err is set (must be at least 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, on clk rising edge.
- im_stall  in  1  I-cache not ready with the fetch word.
- dm_stall  in  1  D-cache not ready with the MEM-stage access.
- ex_busy  in  1  multi-cycle EX unit (mul/div) still computing.
- branch_taken  in  1  EX-stage redirect (branch taken or jump).
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
- cnt_clr  in  1  synchronous clear of the counters and timeout_err.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold the named register.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero control) into the named register.
- stall_cnt  out  CNT_W  cycles with any stall output high.
- flush_cnt  out  CNT_W  redirects taken.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- State machine: RUN and FREEZE, held in a register.
  - freeze_req = im_stall | dm_stall.
  - RUN→FREEZE when freeze_req. FREEZE→RUN when !freeze_req.
- Control outputs are combinational from the current inputs plus the registered state.
  - Effect on the pipeline registers: same cycle, so zero latency.
- Priority 1, freeze_req high:
  - All five stall outputs = 1.
  - All flush outputs = 0.
  - Nothing advances and no bubble is inserted.
- Priority 2, ex_busy high:
  - pc_stall, if_id_stall, id_ex_stall = 1.
  - ex_mem_flush = 1 (bubble into MEM).
  - branch_taken and load-use are ignored while EX holds.
- Priority 3, redirect = branch_taken | pend_redirect:
  - if_id_flush = 1 and id_ex_flush = 1.
  - No stalls.
  - flush_cnt increments by 1.
  - pend_redirect clears.
  - Load-use is ignored in the same cycle, because the ID instruction is squashed.
- Priority 4, load-use:
  - Condition: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1, for exactly one cycle per hazard.
- Otherwise all stall and flush outputs = 0.
- pend_redirect register:
  - Set when branch_taken is high during freeze_req or ex_busy.
  - Guarantees exactly one flush on the first advancing cycle, even if branch_taken drops before then.
  - Cleared by that flush.
- Freeze timer:
  - Counts consecutive FREEZE cycles.
  - Saturates at FREEZE_TMO; timeout_err is set when it reaches FREEZE_TMO.
  - Returns to 0 on FREEZE→RUN.
  - timeout_err stays set until rst or cnt_clr.
- Counters:
  - stall_cnt increments in every cycle where any *_stall output = 1.
  - Both counters wrap modulo 2^CNT_W.
  - cnt_clr has priority over increment in the same cycle.
- Reset:
  - State = RUN; pend_redirect, freeze timer, counters and timeout_err = 0.
  - All stall and flush outputs are forced to 0 while rst = 1, including reset asserted mid-freeze.
  - Outputs are driven from inputs again on the first cycle after rst deasserts.
- Simultaneous im_stall & dm_stall: a single freeze; the timer counts it once.

Decomposition:
- Shared package (pipeline defines):
  - State enum: ST_RUN, ST_FREEZE.
  - Stage-index constants.
  - Struct pipe_ctrl_t bundling the 5 stall and 3 flush bits.
- One natural sub-module: hazard_perf_cnt, holding stall_cnt, flush_cnt, the freeze timer and timeout_err.

Test Plan:
- Freeze during redirect:
  - Stimulus: dm_stall=1 for 3 cycles, with branch_taken=1 in cycle 2 only.
  - Required: all stalls=1 for 3 cycles, flushes=0; in cycle 4, if_id_flush=id_ex_flush=1 exactly once; flush_cnt=1, stall_cnt=3.
- Load-use, matching:
  - Stimulus: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
  - Required: pc_stall=if_id_stall=id_ex_flush=1 for one cycle.
- Load-use, non-matching:
  - Stimulus: same as above with ex_rd=0, or id_use_rs2=0.
  - Required: all outputs 0.
- EX busy with branch:
  - Stimulus: ex_busy=1 for 4 cycles with branch_taken=1 throughout.
  - Required: ex_mem_flush=1 plus the upstream stalls for 4 cycles; one redirect flush in cycle 5.
- Watchdog:
  - Stimulus: FREEZE_TMO=4, im_stall held 6 cycles.
  - Required: timeout_err rises after the 4th freeze cycle and stays set after im_stall drops; cnt_clr clears it and both counters to 0.
- Reset mid-freeze:
  - Stimulus: rst=1 asserted during dm_stall=1.
  - Required: stall outputs 0 while rst=1; state RUN on release; dm_stall still high gives all stalls=1 again the next cycle.
